bidir_boundary_scan_register: RTL

Parametrised bidirectional boundary-scan register: per pin one input cell, one output cell and one output-enable cell, chained between `tdi` and `tdo`. It sits between the core pad ring signals and the physical pads, controlled by the TAP controller's DR enables. It supports:
- SAMPLE/PRELOAD, where the core passes through transparently.
- EXTEST, where pads are driven from the update stage.
- INTEST, where the core inputs are driven from the update stage.

---
 rtl/jtag_bsr_pkg.sv | 25 ++
 rtl/bidir_bsr_pin.sv | 69 ++++++
 rtl/bidir_boundary_scan_register.sv | 78 +++++++
 3 files changed

// File: rtl/jtag_bsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_bsr_pkg
//  Description : Shared definitions for the bidirectional boundary-scan
//                register: per-pin cell ordering inside the scan chain and
//                the cell-type enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_bsr_pkg;

    // Position of each cell inside one pin's three-bit chain segment.
    // The input cell is nearest tdi, the OE cell nearest tdo.
    localparam int BSR_IN_IDX        = 0;
    localparam int BSR_OUT_IDX       = 1;
    localparam int BSR_OE_IDX        = 2;
    localparam int BSR_CELLS_PER_PIN = 3;

    typedef enum logic [1:0] {
        CELL_IN  = 2'd0,
        CELL_OUT = 2'd1,
        CELL_OE  = 2'd2
    } bsr_cell_e;

endpackage : jtag_bsr_pkg
`default_nettype wire

// File: rtl/bidir_bsr_pin.sv
`default_nettype none
// ============================================================================
//  Module      : bidir_bsr_pin
//  Description : One bidirectional pin of the boundary-scan register: three
//                shift-stage cells (input, output, OE), three update-stage
//                cells and the pad/core multiplexers.
//  Ports       : tck, reset (async, active-low), capture_dr / shift_dr /
//                update_dr DR enables, mode_extest / mode_intest selects,
//                scan_in / scan_out chain links, pad_in / core_out / core_oe
//                sources, core_in / pad_out / pad_oe muxed outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module bidir_bsr_pin
    import jtag_bsr_pkg::*;
#(
    // Update-stage value loaded on reset, indexed by cell position.
    parameter logic [BSR_CELLS_PER_PIN-1:0] UPD_RESET = '0
) (
    input  logic tck,
    input  logic reset,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_dr,
    input  logic mode_extest,
    input  logic mode_intest,
    input  logic scan_in,
    output logic scan_out,
    input  logic pad_in,
    input  logic core_out,
    input  logic core_oe,
    output logic core_in,
    output logic pad_out,
    output logic pad_oe
);

    logic [BSR_CELLS_PER_PIN-1:0] r_shift;
    logic [BSR_CELLS_PER_PIN-1:0] r_upd;

    // Capture has priority over shift when both enables are present.
    always_ff @(posedge tck or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (capture_dr) begin
            r_shift[BSR_IN_IDX]  <= pad_in;
            r_shift[BSR_OUT_IDX] <= core_out;
            r_shift[BSR_OE_IDX]  <= core_oe;
        end else if (shift_dr) begin
            r_shift <= {r_shift[BSR_CELLS_PER_PIN-2:0], scan_in};
        end
    end

    // Non-blocking semantics give the update stage the pre-shift contents
    // when shift_dr and update_dr coincide.
    always_ff @(posedge tck or negedge reset) begin
        if (!reset) begin
            r_upd <= UPD_RESET;
        end else if (update_dr) begin
            r_upd <= r_shift;
        end
    end

    assign scan_out = r_shift[BSR_CELLS_PER_PIN-1];

    assign pad_out = mode_extest ? r_upd[BSR_OUT_IDX] : core_out;
    assign pad_oe  = mode_extest ? r_upd[BSR_OE_IDX]  : core_oe;
    assign core_in = mode_intest ? r_upd[BSR_IN_IDX]  : pad_in;

endmodule : bidir_bsr_pin
`default_nettype wire

// File: rtl/bidir_boundary_scan_register.sv
`default_nettype none
// ============================================================================
//  Module      : bidir_boundary_scan_register
//  Description : Parametrised bidirectional boundary-scan register. One
//                bidir_bsr_pin per pin, chained tdi -> pin 0 -> ... ->
//                pin NUM_PINS-1 -> tdo (chain length 3*NUM_PINS).
//  Ports       : tck clock, reset (async, active-low), capture_dr /
//                shift_dr / update_dr, mode_extest / mode_intest, tdi / tdo,
//                pad_in / core_out / core_oe in, core_in / pad_out / pad_oe
//                out (all NUM_PINS wide).
//  Macro       : BSR_SAFE_STATE_EN - when defined, reset loads the update
//                stage with SAFE_OUT / SAFE_OE instead of zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module bidir_boundary_scan_register
    import jtag_bsr_pkg::*;
#(
    parameter int                  NUM_PINS = 4,
    parameter logic [NUM_PINS-1:0] SAFE_OUT = '0,
    parameter logic [NUM_PINS-1:0] SAFE_OE  = '0
) (
    input  logic                tck,
    input  logic                reset,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic                mode_extest,
    input  logic                mode_intest,
    input  logic                tdi,
    output logic                tdo,
    input  logic [NUM_PINS-1:0] pad_in,
    input  logic [NUM_PINS-1:0] core_out,
    input  logic [NUM_PINS-1:0] core_oe,
    output logic [NUM_PINS-1:0] core_in,
    output logic [NUM_PINS-1:0] pad_out,
    output logic [NUM_PINS-1:0] pad_oe
);

`ifdef BSR_SAFE_STATE_EN
    localparam logic c_safe_en = 1'b1;
`else
    localparam logic c_safe_en = 1'b0;
`endif

    // w_link[i] feeds pin i; w_link[NUM_PINS] is the last OE flop itself.
    logic [NUM_PINS:0] w_link;

    assign w_link[0] = tdi;
    assign tdo       = w_link[NUM_PINS];

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        // Input cell never has a safe value; it always resets to 0.
        localparam logic [BSR_CELLS_PER_PIN-1:0] c_upd_reset =
            c_safe_en ? {SAFE_OE[i], SAFE_OUT[i], 1'b0} : '0;

        bidir_bsr_pin #(
            .UPD_RESET (c_upd_reset)
        ) u_pin (
            .tck         (tck),
            .reset       (reset),
            .capture_dr  (capture_dr),
            .shift_dr    (shift_dr),
            .update_dr   (update_dr),
            .mode_extest (mode_extest),
            .mode_intest (mode_intest),
            .scan_in     (w_link[i]),
            .scan_out    (w_link[i+1]),
            .pad_in      (pad_in[i]),
            .core_out    (core_out[i]),
            .core_oe     (core_oe[i]),
            .core_in     (core_in[i]),
            .pad_out     (pad_out[i]),
            .pad_oe      (pad_oe[i])
        );
    end

endmodule : bidir_boundary_scan_register
`default_nettype wire
